// File: rtl/comp_pkg.sv
// +----------------------------------------------------------------------+
// | comp_pkg: field/key geometry and FSM encoding for instr_compressor    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package comp_pkg;
  localparam int INSTR_WIDTH      = 32;
  localparam int FIELD1_VAL_WIDTH = 7;
  localparam int FIELD2_VAL_WIDTH = 10;
  localparam int FIELD3_VAL_WIDTH = 15;
  localparam int FIELD1_KEY_WIDTH = 3;
  localparam int FIELD2_KEY_WIDTH = 5;
  localparam int FIELD3_KEY_WIDTH = 8;
  localparam int KEY_WIDTH        = FIELD1_KEY_WIDTH + FIELD2_KEY_WIDTH + FIELD3_KEY_WIDTH;

  localparam int FIELD1_LSB = 0;
  localparam int FIELD2_LSB = FIELD1_LSB + FIELD1_VAL_WIDTH;
  localparam int FIELD3_LSB = FIELD2_LSB + FIELD2_VAL_WIDTH;
  localparam int KEY1_LSB   = 0;
  localparam int KEY2_LSB   = KEY1_LSB + FIELD1_KEY_WIDTH;
  localparam int KEY3_LSB   = KEY2_LSB + FIELD2_KEY_WIDTH;

  // Search length is set by the deepest dictionary.
  localparam int                          SEARCH_W    = FIELD3_KEY_WIDTH;
  localparam logic [FIELD3_KEY_WIDTH-1:0] SEARCH_LAST = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

`default_nettype wire

// File: rtl/dict_bank.sv
// +----------------------------------------------------------------------+
// | dict_bank: append-only dictionary with fill count and indexed match   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dict_bank #(
  parameter int VAL_W = 7,
  parameter int KEY_W = 3,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_allow,
  input  logic             wr_en,
  input  logic [VAL_W-1:0] wr_val,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [VAL_W-1:0] cmp_val,
  output logic             match,
  output logic             full
);
  localparam int DEPTH = 2 ** KEY_W;

  logic [VAL_W-1:0] mem_q [DEPTH];
  logic [KEY_W:0]   count_q;
  logic [KEY_W:0]   count_d;
  logic [IDX_W:0]   count_ext;
  logic [VAL_W-1:0] rd_val;
  logic             wr_fire;

  assign full    = count_q[KEY_W];
  assign wr_fire = wr_allow && wr_en && !full;

  always_comb begin
    count_d = count_q;
    if (wr_fire) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  // Storage is deliberately not reset; the fill count alone gates matching.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[count_q[KEY_W-1:0]] <= wr_val;
  end

  always_comb begin
    count_ext = '0;
    count_ext[KEY_W:0] = count_q;
  end

  assign rd_val = mem_q[rd_idx[KEY_W-1:0]];
  assign match  = ({1'b0, rd_idx} < count_ext) && (rd_val == cmp_val);
endmodule

`default_nettype wire

// File: rtl/instr_compressor.sv
// +----------------------------------------------------------------------+
// | instr_compressor: dictionary search producing a 16-bit compressed key |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_compressor
  import comp_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        dict1_write_enable,
  input  logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  input  logic                        dict2_write_enable,
  input  logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  input  logic                        dict3_write_enable,
  input  logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic [2:0]                  dict_full,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INSTR_WIDTH-1:0]      in_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KEY_WIDTH-1:0]        out_key,
  output logic [2:0]                  out_hit,
  output logic                        out_compressible,
  output logic [INSTR_WIDTH-1:0]      out_instr
);
  logic [1:0]                  state_q, state_d;
  logic [SEARCH_W-1:0]         idx_q, idx_d;
  logic [2:0]                  hit_q, hit_d;
  logic [FIELD1_KEY_WIDTH-1:0] key1_q, key1_d;
  logic [FIELD2_KEY_WIDTH-1:0] key2_q, key2_d;
  logic [FIELD3_KEY_WIDTH-1:0] key3_q, key3_d;
  logic [INSTR_WIDTH-1:0]      instr_q, instr_d;
  logic [2:0]                  match;

  assign in_ready = (state_q == ST_IDLE);

  dict_bank #(.VAL_W(FIELD1_VAL_WIDTH), .KEY_W(FIELD1_KEY_WIDTH), .IDX_W(SEARCH_W)) u_dict1 (
    .clk(clk), .resetn(resetn), .wr_allow(in_ready),
    .wr_en(dict1_write_enable), .wr_val(dict1_write_val), .rd_idx(idx_q),
    .cmp_val(instr_q[FIELD1_LSB +: FIELD1_VAL_WIDTH]), .match(match[0]), .full(dict_full[0])
  );

  dict_bank #(.VAL_W(FIELD2_VAL_WIDTH), .KEY_W(FIELD2_KEY_WIDTH), .IDX_W(SEARCH_W)) u_dict2 (
    .clk(clk), .resetn(resetn), .wr_allow(in_ready),
    .wr_en(dict2_write_enable), .wr_val(dict2_write_val), .rd_idx(idx_q),
    .cmp_val(instr_q[FIELD2_LSB +: FIELD2_VAL_WIDTH]), .match(match[1]), .full(dict_full[1])
  );

  dict_bank #(.VAL_W(FIELD3_VAL_WIDTH), .KEY_W(FIELD3_KEY_WIDTH), .IDX_W(SEARCH_W)) u_dict3 (
    .clk(clk), .resetn(resetn), .wr_allow(in_ready),
    .wr_en(dict3_write_enable), .wr_val(dict3_write_val), .rd_idx(idx_q),
    .cmp_val(instr_q[FIELD3_LSB +: FIELD3_VAL_WIDTH]), .match(match[2]), .full(dict_full[2])
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    key1_d  = key1_q;
    key2_d  = key2_q;
    key3_d  = key3_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SEARCH;
          instr_d = in_instr;
          idx_d   = '0;
          hit_d   = '0;
          key1_d  = '0;
          key2_d  = '0;
          key3_d  = '0;
        end
      end
      ST_SEARCH: begin
        // A field keeps its first (lowest-index) hit; later duplicates are ignored.
        if (!hit_q[0] && match[0]) begin
          hit_d[0] = 1'b1;
          key1_d   = idx_q[FIELD1_KEY_WIDTH-1:0];
        end
        if (!hit_q[1] && match[1]) begin
          hit_d[1] = 1'b1;
          key2_d   = idx_q[FIELD2_KEY_WIDTH-1:0];
        end
        if (!hit_q[2] && match[2]) begin
          hit_d[2] = 1'b1;
          key3_d   = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if ((&hit_d) || (idx_q == SEARCH_LAST)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hit_q   <= '0;
      key1_q  <= '0;
      key2_q  <= '0;
      key3_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      key1_q  <= key1_d;
      key2_q  <= key2_d;
      key3_q  <= key3_d;
      instr_q <= instr_d;
    end
  end

  assign out_valid        = (state_q == ST_DONE);
  assign out_key          = {key3_q, key2_q, key1_q};
  assign out_hit          = hit_q;
  assign out_compressible = &hit_q;
  assign out_instr        = instr_q;
endmodule

`default_nettype wire
